gci_std_display_cmd_buffer: RTL

Request/response buffer placed directly upstream of the display device on the GCI data bus. It absorbs bus requests into a command FIFO and replays them into the display device under its busy handshake. It collects the device's one-cycle-later responses into a response FIFO and returns them in order to the bus master. Out-of-range or misaligned addresses are filtered locally, so they never reach the display controller.

---
 rtl/gci_std_display_cmd_buffer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/gci_std_display_cmd_buffer.sv
// Request/response buffer between the GCI data bus and the display device.
// Latency: request accepted in cycle N -> oDEV_REQ in N+1; device reply in N+2 -> oUP_REQ in N+3.
// Backpressure: oUP_BUSY = command FIFO full; device issue is held by iDEV_BUSY and response-FIFO room.
//
// Ports:
//   iCLOCK/iRESET        : clock, async active-high reset
//   iUP_* / oUP_BUSY     : bus request in (RW, ADDR, DATA)
//   oUP_REQ/DATA, iUP_BUSY : in-order response out to the bus master
//   oDEV_* / iDEV_BUSY   : command FIFO head replayed into the display device
//   iDEV_REQ/DATA        : device response (one cycle after issue, cannot stall)
//   iERR_CLR / oERR      : sticky error flag (dropped request or unexpected response)

// Generic FIFO: head visible combinationally from registered storage.
// Push while full is legal only together with a pop (the pop frees the slot).
module gci_std_display_cmd_buffer_fifo #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [DEPTH_N:0] count
);
  logic [W-1:0]       mem_q [DEPTH];
  logic [W-1:0]       mem_d [DEPTH];
  logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_N:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared so the head fields read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module gci_std_display_cmd_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          DEPTH_N  = 2,
  parameter logic [31:0] ADDR_MAX = 32'h001383FC
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iUP_REQ,
  output logic        oUP_BUSY,
  input  logic        iUP_RW,
  input  logic [31:0] iUP_ADDR,
  input  logic [31:0] iUP_DATA,
  output logic        oUP_REQ,
  input  logic        iUP_BUSY,
  output logic [31:0] oUP_DATA,
  output logic        oDEV_REQ,
  input  logic        iDEV_BUSY,
  output logic        oDEV_RW,
  output logic [31:0] oDEV_ADDR,
  output logic [31:0] oDEV_DATA,
  input  logic        iDEV_REQ,
  input  logic [31:0] iDEV_DATA,
  input  logic        iERR_CLR,
  output logic        oERR
);
  localparam logic [DEPTH_N:0] FULL_CNT = (DEPTH_N+1)'(DEPTH);

  // Command entry layout: {rw, addr, data, bad}
  logic [65:0]      cmd_in, cmd_head;
  logic [DEPTH_N:0] cmd_count, resp_count;
  logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic             resp_push, resp_pop, resp_full, resp_empty;
  logic [31:0]      resp_in, resp_head;
  logic             up_bad, head_bad, room, issue, retire, rsp_ok, rsp_stray;
  logic [1:0]       outstanding_q, outstanding_d;
  logic             err_q, err_d;

  assign cmd_full   = (cmd_count == FULL_CNT);
  assign cmd_empty  = (cmd_count == '0);
  assign resp_full  = (resp_count == FULL_CNT);
  assign resp_empty = (resp_count == '0);

  assign up_bad   = (iUP_ADDR[1:0] != 2'b00) || (iUP_ADDR > ADDR_MAX);
  assign cmd_push = iUP_REQ && !cmd_full;
  assign cmd_in   = {iUP_RW, iUP_ADDR, iUP_DATA, up_bad};
  assign head_bad = cmd_head[0];

  // Reserve a response slot for every in-flight command, since the device
  // reply cannot be stalled.
  assign room     = (int'(resp_count) + int'(outstanding_q)) < DEPTH;
  assign oDEV_REQ = !cmd_empty && !head_bad && room;
  assign issue    = oDEV_REQ && !iDEV_BUSY;

  // A bad head only retires once everything ahead of it has responded, so its
  // zero response lands in request order and never collides with a device push.
  assign retire    = !cmd_empty && head_bad && (outstanding_q == 2'd0) && !resp_full;
  assign cmd_pop   = issue || retire;

  assign rsp_ok    = iDEV_REQ && (outstanding_q != 2'd0);
  assign rsp_stray = iDEV_REQ && (outstanding_q == 2'd0);
  assign resp_push = rsp_ok || retire;
  assign resp_in   = retire ? 32'h0 : iDEV_DATA;
  assign resp_pop  = !resp_empty && !iUP_BUSY;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({issue, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + 2'd1;
      2'b01:   outstanding_d = outstanding_q - 2'd1;
      default: outstanding_d = outstanding_q;
    endcase
    err_d = err_q;
    if (rsp_stray || retire) begin
      err_d = 1'b1;
    end else if (iERR_CLR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      outstanding_q <= 2'd0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  gci_std_display_cmd_buffer_fifo #(.W(66), .DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) u_cmd_fifo (
    .clk      (iCLOCK),
    .rst      (iRESET),
    .push     (cmd_push),
    .push_dat (cmd_in),
    .pop      (cmd_pop),
    .head_dat (cmd_head),
    .count    (cmd_count)
  );

  gci_std_display_cmd_buffer_fifo #(.W(32), .DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) u_resp_fifo (
    .clk      (iCLOCK),
    .rst      (iRESET),
    .push     (resp_push),
    .push_dat (resp_in),
    .pop      (resp_pop),
    .head_dat (resp_head),
    .count    (resp_count)
  );

  assign oUP_BUSY  = cmd_full;
  assign oUP_REQ   = !resp_empty;
  assign oUP_DATA  = resp_head;
  assign oDEV_RW   = cmd_head[65];
  assign oDEV_ADDR = cmd_head[64:33];
  assign oDEV_DATA = cmd_head[32:1];
  assign oERR      = err_q;
endmodule
